indicador_leds_ascensores: RTL and testbench
============================================

Name: indicador_leds_ascensores

Overview:
Parametrised LED status driver for N_ASC elevator cars, replacing the fixed two-car direct mapping. Each car gets a registered 4-LED field: up/down direction, door-open state and a fault/alarm status.
- Illegal direction codes are flagged with a blinking pattern.
- A door held open too long raises a per-car alarm.
- Sits between the per-car elevator controllers and the board LED pins, in the same clock domain as the controllers.

Parameters:
N_ASC, 2, number of elevator cars (>=1)
DIV_BLINK, 25_000_000, clk cycles per blink half-period (>=2); 0.5 s at 50 MHz
DOOR_MAX, 20, blink half-periods a door may stay open before alarm (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
direccion  input  2*N_ASC  car i direction at [2i+1:2i]; 00 idle, 01 up, 10 down, 11 illegal
puertas_abiertas  input  N_ASC  car i door state; 0 closed, 1 open
lamp_test  input  1  forces all LEDs on while high
leds  output  4*N_ASC  car i field at [4i+3:4i]
alarma  output  N_ASC  car i door-open-timeout alarm, level

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous and active-high.
- Inputs:
  - All inputs are synchronous to `clk`; no synchronisers.
  - All inputs are sampled every cycle.
- Reset values: leds=0, alarma=0, prescaler=0, blink=0, all door counters=0.
- Release from reset: counting starts on the first clk edge after `reset` is released.
- Prescaler:
  - pre_cnt counts 0..DIV_BLINK-1 and wraps to 0.
  - tick=1 for the single cycle where pre_cnt==DIV_BLINK-1.
  - The blink register toggles on tick, so the blink period is 2*DIV_BLINK cycles.
- Door timer, per car:
  - door_cnt is cleared in any cycle where puertas_abiertas[i]==0.
  - Otherwise it increments on tick and saturates at DOOR_MAX.
  - If door close and tick coincide, the clear wins.
  - A door that reopens restarts the count from 0.
- alarma[i] = registered (door_cnt==DOOR_MAX).
  - It falls on the cycle after the door closes, i.e. it is visible one cycle after the counter clears.
- Direction decode, per car (err[i] = direccion==11):
  - 00: up=0, down=0.
  - 01: up=1, down=0.
  - 10: up=0, down=1.
  - 11: up=blink, down=blink, err[i]=1.
- LED field for car i:
  - bit0 = up
  - bit1 = down
  - bit2 = door LED: puertas_abiertas[i] when not in alarm; blink when in alarm
  - bit3 = status: alarma_next[i] | err[i]
- Latency:
  - Field bits are registered, so leds reflect inputs one cycle after the input edge.
  - The blink phase appears one cycle after its toggle.
- lamp_test:
  - leds = all ones one cycle after lamp_test rises.
  - Normal fields return one cycle after it falls.
  - Prescaler, door counters and alarma keep running and are unaffected.
- Reset mid-operation: all state clears immediately, asynchronously; no partial count survives.
- Simultaneous alarm and illegal direction: both shown independently; bit3=1, bits1:0 blink, bit2 blinks.
- N_ASC=1: single 4-bit field; no special cases.

Decomposition:
- Shared package `ascensor_pkg`:
  - Direction encodings DIR_NADA=2'b00, DIR_SUBE=2'b01, DIR_BAJA=2'b10, DIR_ILEGAL=2'b11.
  - LED field offsets LED_SUBE=0, LED_BAJA=1, LED_PUERTA=2, LED_ESTADO=3, and field width LEDS_POR_ASC=4.
- Sub-module `canal_led_ascensor`: one car's door counter, alarm register and 4-bit field.
  - Inputs: tick, blink, lamp_test.
  - Instantiated N_ASC times by a generate loop.
- Prescaler and blink register: live in the top module, shared by all channels.
- Counter width: clog2(DOOR_MAX+1) bits, computed in the sub-module.

Test Plan:
All scenarios use DIV_BLINK=4, DOOR_MAX=3, N_ASC=2 unless stated.
1. Reset: assert reset mid-count with door open 2 ticks -> leds=8'h00, alarma=2'b00 immediately. Release reset -> first tick 4 cycles later.
2. Direction map: direccion=4'b10_01, doors closed -> leds=8'h21 one cycle later. direccion=4'b00_00 -> leds=8'h00.
3. Door timeout: car 0 door open continuously.
   - leds[2]=1 one cycle after opening.
   - alarma[0]=1 after the 3rd tick (~12 cycles); leds[3]=1 and leds[2] toggles every 4 cycles.
   - Close door -> alarma[0]=0 and leds[2:3]=0 one cycle later.
4. Close on tick: car 1 door_cnt=2, door closes on the tick cycle -> door_cnt=0 and no alarm. Reopen -> alarm needs 3 full ticks again.
5. Illegal direction: direccion[1:0]=2'b11 -> leds[3]=1 steady, leds[1:0] alternate 00/11 every 4 cycles, alarma[0]=0.
6. Lamp test: hold lamp_test 10 cycles during a car 0 door alarm -> leds=8'hFF throughout, alarma[0] stays 1. Release -> normal field with blinking door LED.
7. Parametrisation: repeat scenario 2 with N_ASC=1 and N_ASC=4 -> field at [4i+3:4i] only, other fields 0.

Source files
------------

// File: rtl/ascensor_pkg.sv
// Shared encodings for the elevator LED indicator: direction codes and the
// bit layout of each car's 4-LED field.
package ascensor_pkg;

  typedef enum logic [1:0] {
    DIR_NADA   = 2'b00,
    DIR_SUBE   = 2'b01,
    DIR_BAJA   = 2'b10,
    DIR_ILEGAL = 2'b11
  } dir_e;

  localparam int LED_SUBE     = 0;
  localparam int LED_BAJA     = 1;
  localparam int LED_PUERTA   = 2;
  localparam int LED_ESTADO   = 3;
  localparam int LEDS_POR_ASC = 4;

endpackage

// File: rtl/canal_led_ascensor.sv
// One car's channel: door-open timer, timeout alarm and registered 4-LED field.
module canal_led_ascensor
  import ascensor_pkg::*;
#(
  parameter int DOOR_MAX = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    blink,
  input  logic                    lamp_test,
  input  logic [1:0]              direccion,
  input  logic                    puerta,
  output logic [LEDS_POR_ASC-1:0] leds,
  output logic                    alarma
);

  localparam int            CW      = $clog2(DOOR_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DOOR_MAX);

  logic [CW-1:0]           r_cnt;
  logic                    r_alarma;
  logic [LEDS_POR_ASC-1:0] r_leds;

  logic [CW-1:0]           w_cnt_next;
  logic                    w_alarma_next;
  logic                    w_sube;
  logic                    w_baja;
  logic                    w_err;
  logic [LEDS_POR_ASC-1:0] w_campo;

  // A closed door clears the count even on a tick cycle.
  always_comb begin
    w_cnt_next = r_cnt;
    if (!puerta)
      w_cnt_next = '0;
    else if (tick && (r_cnt != CNT_MAX))
      w_cnt_next = r_cnt + 1'b1;
  end

  assign w_alarma_next = (w_cnt_next == CNT_MAX);

  always_comb begin
    w_sube = 1'b0;
    w_baja = 1'b0;
    w_err  = 1'b0;
    case (dir_e'(direccion))
      DIR_SUBE: w_sube = 1'b1;
      DIR_BAJA: w_baja = 1'b1;
      DIR_ILEGAL: begin
        w_sube = blink;
        w_baja = blink;
        w_err  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_campo             = '0;
    w_campo[LED_SUBE]   = w_sube;
    w_campo[LED_BAJA]   = w_baja;
    w_campo[LED_PUERTA] = w_alarma_next ? blink : puerta;
    w_campo[LED_ESTADO] = w_alarma_next | w_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_alarma <= 1'b0;
      r_leds   <= '0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_alarma <= w_alarma_next;
      r_leds   <= lamp_test ? '1 : w_campo;
    end
  end

  assign leds   = r_leds;
  assign alarma = r_alarma;

endmodule

// File: rtl/indicador_leds_ascensores.sv
// LED status driver for N_ASC elevator cars: shared blink prescaler feeding
// one LED channel per car.
module indicador_leds_ascensores
  import ascensor_pkg::*;
#(
  parameter int N_ASC     = 2,
  parameter int DIV_BLINK = 25_000_000,
  parameter int DOOR_MAX  = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*N_ASC-1:0]            direccion,
  input  logic [N_ASC-1:0]              puertas_abiertas,
  input  logic                          lamp_test,
  output logic [LEDS_POR_ASC*N_ASC-1:0] leds,
  output logic [N_ASC-1:0]              alarma
);

  localparam int            PW      = (DIV_BLINK > 1) ? $clog2(DIV_BLINK) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV_BLINK - 1);

  logic [PW-1:0] r_pre_cnt;
  logic          r_blink;
  logic          w_tick;

  assign w_tick = (r_pre_cnt == PRE_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre_cnt <= '0;
      r_blink   <= 1'b0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      if (w_tick)
        r_blink <= ~r_blink;
    end
  end

  generate
    for (genvar gi = 0; gi < N_ASC; gi++) begin : g_canal
      canal_led_ascensor #(
        .DOOR_MAX (DOOR_MAX)
      ) u_canal (
        .clk       (clk),
        .reset     (reset),
        .tick      (w_tick),
        .blink     (r_blink),
        .lamp_test (lamp_test),
        .direccion (direccion[2*gi +: 2]),
        .puerta    (puertas_abiertas[gi]),
        .leds      (leds[LEDS_POR_ASC*gi +: LEDS_POR_ASC]),
        .alarma    (alarma[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_indicador_leds_ascensores.sv
// Directed bench: a cycle-by-cycle vector table on a 2-car instance plus
// hand-written reset and 1-car / 4-car parametrisation sequences.
module tb_indicador_leds_ascensores;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  direccion;
  logic [1:0]  puertas;
  logic        lamp_test;
  logic [7:0]  leds;
  logic [1:0]  alarma;

  logic [1:0]  dir1;
  logic        door1;
  logic [3:0]  leds1;
  logic        alarma1;

  logic [7:0]  dir4;
  logic [3:0]  door4;
  logic [15:0] leds4;
  logic [3:0]  alarma4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  indicador_leds_ascensores #(.N_ASC(2), .DIV_BLINK(4), .DOOR_MAX(3)) dut (
    .clk(clk), .reset(reset), .direccion(direccion), .puertas_abiertas(puertas),
    .lamp_test(lamp_test), .leds(leds), .alarma(alarma)
  );

  indicador_leds_ascensores #(.N_ASC(1), .DIV_BLINK(4), .DOOR_MAX(3)) dut1 (
    .clk(clk), .reset(reset), .direccion(dir1), .puertas_abiertas(door1),
    .lamp_test(lamp_test), .leds(leds1), .alarma(alarma1)
  );

  indicador_leds_ascensores #(.N_ASC(4), .DIV_BLINK(4), .DOOR_MAX(3)) dut4 (
    .clk(clk), .reset(reset), .direccion(dir4), .puertas_abiertas(door4),
    .lamp_test(lamp_test), .leds(leds4), .alarma(alarma4)
  );

  typedef struct {
    logic [3:0] dir;
    logic [1:0] door;
    logic       lamp;
    logic [7:0] exp_leds;
    logic [1:0] exp_alarma;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic [3:0] d, logic [1:0] p, logic l,
                              logic [7:0] el, logic [1:0] ea);
    vec_t v;
    v.dir = d; v.door = p; v.lamp = l; v.exp_leds = el; v.exp_alarma = ea;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Edge k counts from reset release; tick on edges 4,8,12,...;
    // blink seen by the LEDs at edge k is ((k-1)/4) % 2.
    add(2,  4'b1001, 2'b00, 1'b0, 8'h21, 2'b00); // 1-2   direction map
    add(1,  4'b0000, 2'b00, 1'b0, 8'h00, 2'b00); // 3
    add(8,  4'b0000, 2'b01, 1'b0, 8'h04, 2'b00); // 4-11  car0 door open
    add(1,  4'b0000, 2'b01, 1'b0, 8'h08, 2'b01); // 12    third tick -> alarm
    add(4,  4'b0000, 2'b01, 1'b0, 8'h0C, 2'b01); // 13-16
    add(4,  4'b0000, 2'b01, 1'b0, 8'h08, 2'b01); // 17-20
    add(10, 4'b0000, 2'b01, 1'b1, 8'hFF, 2'b01); // 21-30 lamp test
    add(2,  4'b0000, 2'b01, 1'b0, 8'h0C, 2'b01); // 31-32
    add(1,  4'b0000, 2'b01, 1'b0, 8'h08, 2'b01); // 33
    add(1,  4'b0000, 2'b00, 1'b0, 8'h00, 2'b00); // 34    close door
    add(9,  4'b0000, 2'b10, 1'b0, 8'h40, 2'b00); // 35-43 car1 open, cnt=2
    add(1,  4'b0000, 2'b00, 1'b0, 8'h00, 2'b00); // 44    close on tick
    add(11, 4'b0000, 2'b10, 1'b0, 8'h40, 2'b00); // 45-55 reopen
    add(1,  4'b0000, 2'b10, 1'b0, 8'hC0, 2'b10); // 56    three new ticks
    add(1,  4'b0000, 2'b10, 1'b0, 8'h80, 2'b10); // 57
    add(1,  4'b0000, 2'b00, 1'b0, 8'h00, 2'b00); // 58
    add(2,  4'b0011, 2'b00, 1'b0, 8'h08, 2'b00); // 59-60 illegal direction
    add(4,  4'b0011, 2'b00, 1'b0, 8'h0B, 2'b00); // 61-64
    add(2,  4'b0011, 2'b00, 1'b0, 8'h08, 2'b00); // 65-66

    reset = 1'b1; direccion = '0; puertas = '0; lamp_test = 1'b0;
    dir1 = '0; door1 = 1'b0; dir4 = '0; door4 = '0;
    step(); step();
    chk("reset_leds", leds, 16'h0000);
    chk("reset_alarma", alarma, 16'h0000);
    chk("reset_leds_n1", leds1, 16'h0000);
    chk("reset_leds_n4", leds4, 16'h0000);

    // Reset mid-count: car0 door open for 2 ticks, then reset asynchronously.
    reset = 1'b0;
    puertas = 2'b01;
    repeat (9) step();
    chk("pre_reset_door", leds, 16'h0004);
    reset = 1'b1;
    #1;
    chk("async_reset_leds", leds, 16'h0000);
    chk("async_reset_alarma", alarma, 16'h0000);
    step();
    chk("held_reset_leds", leds, 16'h0000);
    puertas = 2'b00;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      direccion = vecs[i].dir;
      puertas   = vecs[i].door;
      lamp_test = vecs[i].lamp;
      step();
      $display("[TB] edge %0d dir=%b door=%b lamp=%b leds=%h alarma=%b",
               i + 1, direccion, puertas, lamp_test, leds, alarma);
      chk($sformatf("vec%0d_leds", i + 1), leds, vecs[i].exp_leds);
      chk($sformatf("vec%0d_alarma", i + 1), alarma, vecs[i].exp_alarma);
    end

    // Parametrised instances: only car i's field moves.
    direccion = '0; puertas = '0; lamp_test = 1'b0;
    dir1 = 2'b01; dir4 = 8'b00_00_10_01;
    step();
    $display("[TB] param dir1=%b leds1=%h dir4=%b leds4=%h", dir1, leds1, dir4, leds4);
    chk("n1_up", leds1, 16'h0001);
    chk("n4_cars01", leds4, 16'h0021);
    dir1 = 2'b10; dir4 = 8'b01_10_00_00;
    step();
    $display("[TB] param dir1=%b leds1=%h dir4=%b leds4=%h", dir1, leds1, dir4, leds4);
    chk("n1_down", leds1, 16'h0002);
    chk("n4_cars23", leds4, 16'h1200);
    dir1 = 2'b00; dir4 = 8'h00;
    step();
    $display("[TB] param dir1=%b leds1=%h dir4=%b leds4=%h", dir1, leds1, dir4, leds4);
    chk("n1_idle", leds1, 16'h0000);
    chk("n4_idle", leds4, 16'h0000);
    chk("n1_alarma", alarma1, 16'h0000);
    chk("n4_alarma", alarma4, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
